// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between the fetch stage and instruction memory.
// One request outstanding at most; a beat completes when imem_req and imem_ready are both high.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over the imem bus and feeds the IF/ID register,
// using a one-entry skid buffer for decode stalls and a drop state to discard stale fetches after a redirect.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    if_stage_if.master        imem,
    output logic [31:0]       inst,
    output logic [31:0]       pc_out,
    output logic              valid,
    output logic              flush
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FULL  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] pc;
    logic [31:0] drop_addr;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc;
    logic [31:0] target_pc;
    logic        xfer;
    logic        slot_accept;

    assign target_pc   = redirect_pc & 32'hFFFF_FFFC;
    assign xfer        = imem.imem_req && imem.imem_ready;
    assign slot_accept = !stall || !valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // FULL means the skid buffer holds an entry; DROP means a stale request is still in flight.
    always_comb begin
        next_state = state;
        unique case (state)
            FETCH: begin
                if (redirect) begin
                    next_state = xfer ? FETCH : DROP;
                end else if (xfer && !slot_accept) begin
                    next_state = FULL;
                end
            end
            FULL: begin
                if (redirect || !stall) begin
                    next_state = FETCH;
                end
            end
            DROP: begin
                if (!redirect && xfer) begin
                    next_state = FETCH;
                end
            end
            default: next_state = FETCH;
        endcase
    end

    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc;
        flush          = !valid;
        unique case (state)
            FETCH: imem.imem_req = !rst;
            DROP: begin
                imem.imem_req  = !rst;
                imem.imem_addr = drop_addr;
            end
            default: imem.imem_req = 1'b0;
        endcase
    end

    // Redirect wins over stall everywhere; the abandoned address is kept so DROP can finish that handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            drop_addr <= RESET_PC;
            inst      <= NOP_INST;
            pc_out    <= RESET_PC;
            valid     <= 1'b0;
            skid_inst <= NOP_INST;
            skid_pc   <= RESET_PC;
        end else if (redirect) begin
            pc    <= target_pc;
            inst  <= NOP_INST;
            valid <= 1'b0;
            if (state == FETCH && !xfer) begin
                drop_addr <= pc;
            end
        end else begin
            unique case (state)
                FETCH: begin
                    if (xfer) begin
                        pc <= pc + 32'd4;
                        if (slot_accept) begin
                            inst   <= imem.imem_rdata;
                            pc_out <= pc;
                            valid  <= 1'b1;
                        end else begin
                            skid_inst <= imem.imem_rdata;
                            skid_pc   <= pc;
                        end
                    end else if (slot_accept) begin
                        inst  <= NOP_INST;
                        valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (!stall) begin
                        inst   <= skid_inst;
                        pc_out <= skid_pc;
                        valid  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
